// File: rtl/imm_encoder.sv
// Packs a signed 32-bit immediate into the immediate fields of a RISC-V instruction word.
// Two-stage valid/ready pipeline with range/alignment checks and a saturating error counter.
module imm_encoder #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          base_instr,
  input  logic [31:0]          imm,
  input  logic [2:0]           imm_src,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [2:0]           out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;

  function automatic logic [31:0] field_mask(input logic [2:0] src);
    logic [31:0] m;
    m = 32'h0000_0000;
    case (src)
      FMT_I:   m = 32'hFFF0_0000;
      FMT_S:   m = 32'hFE00_0F80;
      FMT_B:   m = 32'hFE00_0F80;
      FMT_U:   m = 32'hFFFF_F000;
      FMT_J:   m = 32'hFFFF_F000;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  // Invalid formats place nothing, so the base word passes through untouched.
  function automatic logic [31:0] place_imm(input logic [31:0] v, input logic [2:0] src);
    logic [31:0] p;
    p = 32'h0000_0000;
    case (src)
      FMT_I:   p = {v[11:0], 20'h0_0000};
      FMT_S:   p = {v[11:5], 13'h0000, v[4:0], 7'h00};
      FMT_B:   p = {v[12], v[10:5], 13'h0000, v[4:1], v[11], 7'h00};
      FMT_U:   p = {v[31:12], 12'h000};
      FMT_J:   p = {v[20], v[10:1], v[11], v[19:12], 12'h000};
      default: p = 32'h0000_0000;
    endcase
    return p;
  endfunction

  function automatic logic range_err(input logic [31:0] v, input logic [2:0] src);
    logic signed [31:0] sv;
    logic               r;
    sv = v;
    r  = 1'b0;
    case (src)
      FMT_I, FMT_S: r = (sv < -32'sd2048) || (sv > 32'sd2047);
      FMT_B:        r = (sv < -32'sd4096) || (sv > 32'sd4094);
      FMT_U:        r = (v[11:0] != 12'h000);
      FMT_J:        r = (sv < -32'sd1048576) || (sv > 32'sd1048574);
      default:      r = 1'b0;
    endcase
    return r;
  endfunction

  logic                 s1_valid_r;
  logic [31:0]          s1_masked_r;
  logic [31:0]          s1_imm_r;
  logic [2:0]           s1_src_r;
  logic [2:0]           s1_err_r;
  logic                 out_valid_r;
  logic [31:0]          out_instr_r;
  logic [2:0]           out_err_r;
  logic [ERR_CNT_W-1:0] err_count_r;

  logic                 s2_adv_s;
  logic                 in_ready_s;
  logic [2:0]           err_s;
  logic                 out_fire_s;

  // Handshake: a stage moves when the register below it is empty or draining this cycle.
  always_comb begin
    s2_adv_s   = !out_valid_r || out_ready;
    in_ready_s = !s1_valid_r || s2_adv_s;
    out_fire_s = out_valid_r && out_ready;
  end

  // Error flags for the incoming request; an unknown format suppresses the other two.
  always_comb begin
    err_s = 3'b000;
    if (imm_src > FMT_J) begin
      err_s = 3'b100;
    end else begin
      err_s[0] = range_err(imm, imm_src);
      err_s[1] = ((imm_src == FMT_B) || (imm_src == FMT_J)) && imm[0];
      err_s[2] = 1'b0;
    end
  end

  // Stage 1: capture the request with its immediate fields already cleared from the base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_masked_r <= 32'h0000_0000;
      s1_imm_r    <= 32'h0000_0000;
      s1_src_r    <= 3'b000;
      s1_err_r    <= 3'b000;
    end else if (in_ready_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_masked_r <= base_instr & ~field_mask(imm_src);
        s1_imm_r    <= imm;
        s1_src_r    <= imm_src;
        s1_err_r    <= err_s;
      end else begin
        s1_masked_r <= s1_masked_r;
      end
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_instr_r <= 32'h0000_0000;
      out_err_r   <= 3'b000;
    end else if (s2_adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_instr_r <= s1_masked_r | place_imm(s1_imm_r, s1_src_r);
        out_err_r   <= s1_err_r;
      end else begin
        out_instr_r <= out_instr_r;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Error counter: counts handed-off errored results, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_r <= {ERR_CNT_W{1'b0}};
    end else if (out_fire_s && (out_err_r != 3'b000) && !(&err_count_r)) begin
      err_count_r <= err_count_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_instr = out_instr_r;
  assign out_err   = out_err_r;
  assign err_count = err_count_r;

endmodule
